muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameters SHALL be: XLEN, 64, datapath width (32 or 64); WORD_OPS, 1, enables 32-bit word variants (ignored when XLEN=32).
REQ-002 clk_i  input  1  single clock, all state updates on rising edge.
REQ-003 rst_i  input  1  reset; synchronous, active-high.
REQ-004 valid_i  input  1  request valid.
REQ-005 ready_o  output  1  unit can accept a request.
REQ-006 opr_a_i  input  XLEN  operand A (multiplicand / dividend).
REQ-007 opr_b_i  input  XLEN  operand B (multiplier / divisor).
REQ-008 md_func_i  input  3  operation: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
REQ-009 word_op_i  input  1  32-bit word operation, result sign-extended to XLEN.
REQ-010 flush_i  input  1  abort any in-flight operation.
REQ-011 valid_o  output  1  result valid.
REQ-012 ready_i  input  1  consumer accepts result.
REQ-013 md_res_o  output  XLEN  result.

Function
REQ-014 Unit SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-015 ready_o SHALL be 1 only in IDLE; accept occurs on a clock edge with valid_i & ready_o.
REQ-016 Accept SHALL register operands, md_func_i and word_op_i; later input changes SHALL have no effect.
REQ-017 Word ops SHALL use operand bits [31:0], sign- or zero-extended per function signedness, and SHALL produce {32{r[31]}, r[31:0]}.
REQ-018 MUL SHALL return low XLEN bits of the product; MULH/MULHSU/MULHU SHALL return high XLEN bits (signed x signed, signed x unsigned, unsigned x unsigned).
REQ-019 Division SHALL truncate toward zero; remainder sign SHALL equal dividend sign.
REQ-020 Divide by zero: quotient SHALL be all ones, remainder SHALL be dividend (word-extended for word ops).
REQ-021 Signed overflow (most-negative / -1): quotient SHALL be dividend, remainder SHALL be 0.
REQ-022 Divide-by-zero and overflow SHALL bypass BUSY: IDLE -> DONE, valid_o high 1 cycle after accept.
REQ-023 Otherwise IDLE -> BUSY; BUSY SHALL run N single-bit iterations (shift-add multiply, restoring divide), N = 32 for word ops, else XLEN.
REQ-024 Sign correction SHALL occur on the final iteration; BUSY -> DONE with valid_o high exactly N+1 cycles after accept.
REQ-025 In DONE, md_res_o SHALL be held stable until valid_o & ready_i; then DONE -> IDLE, ready_o high the next cycle.
REQ-026 No request SHALL be accepted in the cycle a result is consumed (no DONE-to-BUSY bypass).
REQ-027 flush_i SHALL force IDLE on the next edge from any state, drop any result, and block acceptance in the flush cycle; flush_i SHALL take priority over ready_i and valid_i.
REQ-028 Invalid md_func_i values are not possible with a 3-bit encoding; all eight codes SHALL be decoded.

Reset
REQ-029 rst_i SHALL, at the next edge, force IDLE, valid_o=0, md_res_o=0 and ready_o=1, and clear the iteration counter, including mid-operation.
REQ-030 rst_i SHALL take priority over flush_i and all handshakes.

Structure
REQ-031 md_func encodings and the FSM state enum SHALL live in the shared cpu_consts package.
REQ-032 The iteration counter SHALL be clog2(XLEN)+1 bits wide.
REQ-033 A single sub-module, muldiv_iter, SHALL hold the shared shift/add-subtract datapath; the FSM and handshake stay in muldiv_unit.

Verification
REQ-034 MUL, A=7, B=-3 -> 0xFFFF_FFFF_FFFF_FFEB, valid_o at cycle 65.
REQ-035 MULHU, A=B=all ones -> 0xFFFF_FFFF_FFFF_FFFE.
REQ-036 DIV 5/0 -> 0xFFFF_FFFF_FFFF_FFFF at cycle 1; REM 5/0 -> 5.
REQ-037 DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000 at cycle 1; DIVW 0x8000_0000 / 0xFFFF_FFFF -> 0xFFFF_FFFF_8000_0000.
REQ-038 REMW -7/2, word op -> 0xFFFF_FFFF_FFFF_FFFF at cycle 33; with ready_i low for 5 cycles, result stable and ready_o low.
REQ-039 flush_i at BUSY cycle 10 -> IDLE next cycle, no valid_o; a new DIVU 100/7 -> 14; rst_i mid-BUSY gives the same outcome.

Source files
------------

// File: rtl/cpu_consts.sv
// Shared encodings for the multiply/divide unit: operation codes and control states.
package cpu_consts;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_func_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    localparam int unsigned WORD_W = 32;

endpackage

// File: rtl/muldiv_iter.sv
// One iteration of the shared datapath: shift-add multiply step or restoring divide step,
// both through a single XLEN+1 bit adder.
module muldiv_iter #(
    parameter int XLEN = 64
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] hi_next,
    output logic [XLEN-1:0] lo_next
);

    logic [XLEN:0] x;
    logic [XLEN:0] y;
    logic [XLEN:0] sum;

    always_comb begin
        // Divide subtracts the divisor from the shifted partial remainder; multiply adds it.
        x       = is_div ? {hi, lo[XLEN-1]} : {1'b0, hi};
        y       = is_div ? ~{1'b0, b} : (lo[0] ? {1'b0, b} : '0);
        sum     = x + y + (XLEN+1)'(is_div);
        hi_next = sum[XLEN:1];
        lo_next = {sum[0], lo[XLEN-1:1]};
        if (is_div) begin
            hi_next = sum[XLEN] ? x[XLEN-1:0] : sum[XLEN-1:0];
            lo_next = {lo[XLEN-2:0], ~sum[XLEN]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with valid/ready handshakes, word variants and flush.
module muldiv_unit
    import cpu_consts::*;
#(
    parameter int XLEN     = 64,
    parameter bit WORD_OPS = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [XLEN-1:0] opr_a_i,
    input  logic [XLEN-1:0] opr_b_i,
    input  logic [2:0]      md_func_i,
    input  logic            word_op_i,
    input  logic            flush_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] md_res_o
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam bit HAS_WORD = WORD_OPS && (XLEN == 64);
    localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] WMIN = ~XLEN'(32'h7FFF_FFFF);

    function automatic logic [XLEN-1:0] sext_word(input logic [WORD_W-1:0] x);
        return XLEN'($signed(x));
    endfunction

    function automatic logic [XLEN-1:0] fit(input logic [XLEN-1:0] x, input logic word);
        return word ? sext_word(x[WORD_W-1:0]) : x;
    endfunction

    function automatic logic [XLEN-1:0] ext_opr(input logic [XLEN-1:0] x, input logic word,
                                                input logic sgn);
        if (!word) return x;
        return sgn ? sext_word(x[WORD_W-1:0]) : XLEN'(x[WORD_W-1:0]);
    endfunction

    md_state_e       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [XLEN-1:0] hi_reg, lo_reg, b_reg, md_res_reg;
    md_func_e        func_reg;
    logic            word_reg, neg_q_reg, neg_r_reg;

    md_func_e        func_in;
    logic            word_in, signed_a, signed_b, is_div_in, is_rem_in;
    logic            a_neg, b_neg, div_zero, div_ovf, bypass, accept, last_iter;
    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, bypass_res, fin_res, quo, rem;
    logic [XLEN-1:0] iter_hi, iter_lo;
    logic [2*XLEN-1:0] prod, prod_s;

    always_comb begin
        func_in   = md_func_e'(md_func_i);
        word_in   = HAS_WORD && word_op_i;
        signed_a  = func_in inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
        signed_b  = func_in inside {MD_MULH, MD_DIV, MD_REM};
        is_div_in = md_func_i[2];
        is_rem_in = md_func_i[2] & md_func_i[1];
        a_ext     = ext_opr(opr_a_i, word_in, signed_a);
        b_ext     = ext_opr(opr_b_i, word_in, signed_b);
        a_neg     = signed_a & a_ext[XLEN-1];
        b_neg     = signed_b & b_ext[XLEN-1];
        a_mag     = a_neg ? -a_ext : a_ext;
        b_mag     = b_neg ? -b_ext : b_ext;
        div_zero  = is_div_in && (b_ext == '0);
        div_ovf   = is_div_in && signed_b && (a_ext == (word_in ? WMIN : XMIN)) && (b_ext == '1);
        bypass    = div_zero || div_ovf;
        bypass_res = '0;
        if (div_zero)
            bypass_res = is_rem_in ? fit(a_ext, word_in) : '1;
        else if (div_ovf)
            bypass_res = is_rem_in ? '0 : fit(a_ext, word_in);
    end

    muldiv_iter #(.XLEN(XLEN)) u_iter (
        .is_div  (func_reg[2]),
        .hi      (hi_reg),
        .lo      (lo_reg),
        .b       (b_reg),
        .hi_next (iter_hi),
        .lo_next (iter_lo)
    );

    // Sign correction is applied to the outputs of the final iteration step.
    always_comb begin
        prod   = {iter_hi, iter_lo} >> (word_reg ? XLEN - WORD_W : 0);
        prod_s = neg_q_reg ? -prod : prod;
        quo    = neg_q_reg ? -iter_lo : iter_lo;
        rem    = neg_r_reg ? -iter_hi : iter_hi;
        case (func_reg)
            MD_MUL:                       fin_res = fit(prod_s[XLEN-1:0], word_reg);
            MD_MULH, MD_MULHSU, MD_MULHU: fin_res = word_reg ? sext_word(prod_s[63:32])
                                                             : prod_s[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              fin_res = fit(quo, word_reg);
            default:                      fin_res = fit(rem, word_reg);
        endcase
        last_iter = (cnt_reg == CNT_W'(word_reg ? WORD_W - 1 : XLEN - 1));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_reg <= MD_IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            MD_IDLE: if (!flush_i && valid_i) state_next = bypass ? MD_DONE : MD_BUSY;
            MD_BUSY: if (flush_i) state_next = MD_IDLE;
                     else if (last_iter) state_next = MD_DONE;
            MD_DONE: if (flush_i || ready_i) state_next = MD_IDLE;
            default: state_next = MD_IDLE;
        endcase
    end

    always_comb begin
        ready_o  = (state_reg == MD_IDLE);
        valid_o  = (state_reg == MD_DONE);
        md_res_o = md_res_reg;
        accept   = ready_o && valid_i && !flush_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_reg    <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            b_reg      <= '0;
            md_res_reg <= '0;
            func_reg   <= MD_MUL;
            word_reg   <= 1'b0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
        end else if (accept) begin
            // Word divides start with the dividend in the top half so 32 steps consume it.
            cnt_reg   <= '0;
            hi_reg    <= '0;
            lo_reg    <= is_div_in ? (a_mag << (word_in ? XLEN - WORD_W : 0)) : b_mag;
            b_reg     <= is_div_in ? b_mag : a_mag;
            func_reg  <= func_in;
            word_reg  <= word_in;
            neg_q_reg <= a_neg ^ b_neg;
            neg_r_reg <= a_neg;
            if (bypass) md_res_reg <= bypass_res;
        end else if (state_reg == MD_BUSY && !flush_i) begin
            cnt_reg <= cnt_reg + 1'b1;
            hi_reg  <= iter_hi;
            lo_reg  <= iter_lo;
            if (last_iter) md_res_reg <= fin_res;
        end
    end

endmodule
